// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INSN = 32'hFFFF_FFFF;
    localparam int          INSN_BYTES        = 4;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instruction} entries between fetch and decode.
module fetch_queue #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Storage is never reset; hide stale contents while empty.
    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC sequencing, one-cycle imem reads, a small instruction
// queue toward decode, redirect handling and halt-on-sentinel.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [DATA_W-1:0] HALT_INSN = DATA_W'(DEFAULT_HALT_INSN)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);

    localparam int                CW         = $clog2(DEPTH + 1);
    localparam int                OW         = CW + 1;
    localparam int                EW         = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSN_BYTES - 1);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc;
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic              deq;
    logic              push;
    logic              halt_seen;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [OW-1:0]     occ;
    logic [EW-1:0]     head;

    // ---- stage p0: request issue ----
    // Occupancy counts the in-flight word so a returning response always has a slot.
    assign deq       = inst_valid & inst_ready;
    assign occ       = OW'(count) + OW'(vld_p1) - OW'(deq);
    assign imem_req  = (state_q == FETCH) & ~redirect_valid & ~rst & (occ < OW'(DEPTH));
    assign imem_addr = pc & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc      <= RESET_PC;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= imem_req;
            if (redirect_valid)
                pc <= redirect_pc & ALIGN_MASK;
            else if (imem_req)
                pc <= pc + ADDR_W'(INSN_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) pc_p1 <= imem_addr;
    end

    // ---- stage p1: response capture ----
    // Responses landing outside FETCH or alongside a redirect are squashed.
    assign push      = vld_p1 & (state_q == FETCH) & ~redirect_valid & ~full;
    assign halt_seen = push & (imem_rdata == HALT_INSN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (halt_seen) state_d = DRAIN;
            DRAIN:   state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
        if (redirect_valid) state_d = FETCH;
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (deq),
        .flush (redirect_valid),
        .din   ({pc_p1, imem_rdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // ---- stage p2: decode handoff ----
    assign inst_valid = ~empty;
    assign inst_pc    = head[EW-1:DATA_W];
    assign inst_data  = head[DATA_W-1:0];
    assign halted     = (state_q == HALTED);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of `datapath`. Holds the PC and issues word reads to the instruction memory.
- Buffers returned instructions in a small queue and hands them to decode with a valid/ready handshake.
- Supports redirect from branch/jump resolution and a halt-on-sentinel mode so that directed programs stop cleanly before testbench sampling.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- DATA_W, 32, instruction word width.
- DEPTH, 2, fetch queue entries; legal values 2..8.
- RESET_PC, 32'h0, PC value loaded on reset.
- HALT_INSN, 32'hFFFF_FFFF, sentinel instruction that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  ADDR_W  word-aligned read address; bits [1:0] always 0.
- imem_rdata  in  DATA_W  read data; valid exactly one cycle after imem_req.
- redirect_valid  in  1  pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are ignored (forced 0).
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  DATA_W  instruction at the queue head.
- inst_pc  out  ADDR_W  PC of inst_data.
- halted  out  1  fetch stopped on HALT_INSN.

Behaviour:
- Reset values:
  - pc = RESET_PC, state = FETCH, queue count = 0, in-flight flag = 0.
  - imem_req = 0 while rst = 1; inst_valid = 0; halted = 0; inst_data and inst_pc = 0.
- States:
  - FETCH: issue requests.
  - DRAIN: sentinel seen; no new requests; in-flight response discarded.
  - HALTED: idle.
- State transitions:
  - FETCH -> DRAIN when a captured response equals HALT_INSN. The sentinel itself is enqueued.
  - DRAIN -> HALTED on the next cycle.
  - Any state -> FETCH on redirect_valid.
- Issue rule:
  - In FETCH, imem_req = 1 when (count + inflight - deq) < DEPTH, where deq = inst_valid & inst_ready.
  - imem_addr = pc. On issue, pc <= pc + 4, wrapping modulo 2^ADDR_W.
- Response:
  - If inflight was set last cycle and not squashed, push {pc_of_req, imem_rdata} at the end of the cycle.
  - Latency: request in cycle C -> inst_valid in cycle C+2.
  - Throughput: 1 instruction/cycle with inst_ready held high and DEPTH >= 2.
- Output handshake:
  - inst_valid, inst_data and inst_pc come from registers only; no combinational path from inputs.
  - Head is popped when inst_valid & inst_ready.
  - Push and pop in the same cycle leaves count unchanged.
- Redirect (highest priority):
  - Queue is flushed (count <= 0).
  - Any in-flight response is squashed: it arrives next cycle and is dropped.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; state <= FETCH; halted <= 0.
  - imem_req is forced 0 in the redirect cycle. The first request at the new PC issues in the following cycle.
  - A pop handshaking in the redirect cycle is considered delivered; decode squashes it itself.
- Simultaneous events:
  - Redirect beats push and halt detection.
  - Redirect during HALTED restarts fetch.
  - Rst beats everything, including mid-flight responses, which are discarded.
- Full/empty:
  - Never push when full; the issue rule guarantees a slot.
  - A pop when empty is a no-op.
  - inst_valid = 0 whenever count = 0.
- halted = 1 in HALTED only.

Decomposition:
- Package `fetch_pkg` holds:
  - enum fetch_state_t {FETCH, DRAIN, HALTED};
  - the defaults for RESET_PC and HALT_INSN;
  - localparam INSN_BYTES = 4.
- Sub-module `fetch_queue`: synchronous FIFO of {pc, data}.
  - Ports: push, pop, flush, full, empty, count.
  - Parameter DEPTH; circular read/write pointers with wrap.

Test Plan:
- Reset release, imem returns word = address, inst_ready = 1 -> imem_addr 0,4,8,... one per cycle; inst_valid first high 2 cycles after the first req; inst_pc/inst_data pairs (0,0), (4,4), (8,8) back-to-back.
- inst_ready = 0 for 6 cycles -> exactly DEPTH = 2 entries held, imem_req drops; on ready = 1, entries pc 0 and pc 4 drain in order with none lost or duplicated.
- redirect_valid with redirect_pc = 32'h43 while one request is in flight -> queue empties next cycle, squashed data never appears, next imem_addr = 32'h40.
- Word at 32'h0C = HALT_INSN -> instructions at 0, 4, 8 and 0C delivered, 10 never delivered, halted = 1 and stays 1; then redirect to 32'h20 -> halted = 0 and fetch resumes at 20.
- Fetch loop from 32'hFFFF_FFF8 -> pc wraps to 0 after FFFF_FFFC with no stall.
- rst asserted one cycle mid-stream with a request in flight -> following cycle inst_valid = 0, count = 0, next request at RESET_PC, stale data dropped.
